// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: control requests, instruction-memory read port and fetch results.
// The fetch unit takes the master modport; the control unit and memory side take slave.
interface instr_fetch_if;
   logic        fetch_start;
   logic        pc_load;
   logic [63:0] pc_target;
   logic        mem_rd;
   logic [63:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] Instr31_0;
   logic [6:0]  opcode;
   logic [63:0] pc;
   logic        instr_valid;
   logic        busy;
   logic        fetch_err;

   modport master (
      input  fetch_start, pc_load, pc_target, mem_ready, mem_rdata,
      output mem_rd, mem_addr, Instr31_0, opcode, pc, instr_valid, busy, fetch_err
   );

   modport slave (
      output fetch_start, pc_load, pc_target, mem_ready, mem_rdata,
      input  mem_rd, mem_addr, Instr31_0, opcode, pc, instr_valid, busy, fetch_err
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, issues one aligned 32-bit read per fetch_start,
// latches the returned word into the instruction register and advances the PC by 4.
// Misaligned fetches and memory timeouts park the unit in a sticky error state.
module instr_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned TIMEOUT  = 15
) (
   input logic            clock,
   input logic            reset,
   instr_fetch_if.master  bus
);

   typedef enum logic [1:0] {StIdle, StFetch, StDone, StErr} state_e;

   // Counter value during the last FETCH cycle allowed before timing out.
   localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

   state_e      state_q;
   logic [63:0] pc_q;
   logic [31:0] ir_q;
   logic [7:0]  cnt_q;
   logic        mem_rd_q;
   logic        instr_valid_q;
   logic        busy_q;
   logic        fetch_err_q;
   logic [63:0] eff_pc;

   // A redirect in the same cycle as fetch_start wins: the fetch uses pc_target.
   always_comb eff_pc = bus.pc_load ? bus.pc_target : pc_q;

   // FSM with outputs registered alongside the state they belong to.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         pc_q          <= RESET_PC;
         ir_q          <= '0;
         cnt_q         <= '0;
         mem_rd_q      <= 1'b0;
         instr_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         fetch_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.pc_load) pc_q <= bus.pc_target;
               if (bus.fetch_start) begin
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
                  if (eff_pc[1:0] != 2'b00) begin
                     state_q     <= StErr;
                     fetch_err_q <= 1'b1;
                  end else begin
                     state_q  <= StFetch;
                     mem_rd_q <= 1'b1;
                  end
               end
            end
            StFetch: begin
               if (bus.mem_ready) begin
                  ir_q          <= bus.mem_rdata;
                  pc_q          <= pc_q + 64'd4;
                  state_q       <= StDone;
                  mem_rd_q      <= 1'b0;
                  instr_valid_q <= 1'b1;
               end else if (cnt_q == LastCnt) begin
                  state_q     <= StErr;
                  mem_rd_q    <= 1'b0;
                  fetch_err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StDone: begin
               state_q       <= StIdle;
               instr_valid_q <= 1'b0;
               busy_q        <= 1'b0;
            end
            StErr: begin
               state_q <= StErr;
            end
         endcase
      end
   end

   assign bus.mem_rd      = mem_rd_q;
   assign bus.mem_addr    = pc_q;
   assign bus.Instr31_0   = ir_q;
   assign bus.opcode      = ir_q[6:0];
   assign bus.pc          = pc_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.busy        = busy_q;
   assign bus.fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: expected instruction/PC pairs are queued when a
// memory response is driven and compared when instr_valid pulses.
module tb_instr_fetch;

   logic clock;
   logic reset;

   instr_fetch_if bus ();

   instr_fetch #(
      .RESET_PC (64'h0),
      .TIMEOUT  (15)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] pc;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_valid  = 0;
   int          n_pushed = 0;
   logic [63:0] m_pc;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard side: every instr_valid pulse must match the oldest queued expectation.
   always @(negedge clock) begin
      if (bus.instr_valid === 1'b1) begin
         n_valid++;
         if (sb.size() == 0) begin
            check_eq("sb_unexpected_valid", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_eq("sb_instr", 64'(bus.Instr31_0), 64'(e.instr));
            check_eq("sb_opcode", 64'(bus.opcode), 64'(e.instr[6:0]));
            check_eq("sb_pc", bus.pc, e.pc);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset           = 1'b1;
      bus.fetch_start = 1'b0;
      bus.pc_load     = 1'b0;
      bus.pc_target   = '0;
      bus.mem_ready   = 1'b0;
      bus.mem_rdata   = '0;
      tick();
      reset = 1'b0;
      m_pc  = 64'h0;
   endtask

   // One fetch: ready withheld for wait_n FETCH cycles, then returned with word.
   task automatic do_fetch(input logic load, input logic [63:0] target, input int wait_n,
                           input logic [31:0] word);
      logic [63:0] addr;
      int          rd_cnt;
      addr            = load ? target : m_pc;
      bus.pc_load     = load;
      bus.pc_target   = target;
      bus.fetch_start = 1'b1;
      bus.mem_ready   = 1'b0;
      tick();
      bus.pc_load     = 1'b0;
      bus.fetch_start = 1'b0;
      rd_cnt          = 0;
      for (int i = 0; i < wait_n; i++) begin
         if (bus.mem_rd === 1'b1) rd_cnt++;
         check_eq("fetch_addr_stable", bus.mem_addr, addr);
         check_eq("fetch_busy", 64'(bus.busy), 64'd1);
         // Redirects and stray data during FETCH must be ignored.
         bus.pc_load   = 1'b1;
         bus.pc_target = 64'hDEAD_0000;
         bus.mem_rdata = $urandom;
         tick();
      end
      if (bus.mem_rd === 1'b1) rd_cnt++;
      check_eq("fetch_addr", bus.mem_addr, addr);
      bus.pc_load   = 1'b0;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = word;
      m_pc          = addr + 64'd4;
      sb.push_back('{instr: word, pc: m_pc});
      n_pushed++;
      tick();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
      check_eq("rd_cycles", 64'(rd_cnt), 64'(wait_n + 1));
      check_eq("done_valid", 64'(bus.instr_valid), 64'd1);
      check_eq("done_rd_low", 64'(bus.mem_rd), 64'd0);
      tick();
      check_eq("idle_valid_low", 64'(bus.instr_valid), 64'd0);
      check_eq("idle_busy_low", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset();
      check_eq("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
      check_eq("rst_valid", 64'(bus.instr_valid), 64'd0);
      check_eq("rst_busy", 64'(bus.busy), 64'd0);
      check_eq("rst_err", 64'(bus.fetch_err), 64'd0);
      check_eq("rst_opcode", 64'(bus.opcode), 64'd0);
      check_eq("rst_addr", bus.mem_addr, 64'h0);
      check_eq("rst_ir", 64'(bus.Instr31_0), 64'd0);

      // Minimum latency fetch
      do_fetch(1'b0, 64'h0, 0, 32'h0050_0093);
      check_eq("lat_opcode", 64'(bus.opcode), 64'h13);
      check_eq("lat_pc", bus.pc, 64'd4);

      // Ready withheld three cycles
      do_reset();
      do_fetch(1'b0, 64'h0, 3, 32'h1234_5678);
      check_eq("wait_pc", bus.pc, 64'd4);
      check_eq("wait_ir_hold", 64'(bus.Instr31_0), 64'h1234_5678);

      // Redirect in the same cycle as fetch_start, then PC wrap
      do_fetch(1'b1, 64'h100, 1, 32'hCAFE_0013);
      check_eq("redir_pc", bus.pc, 64'h104);
      do_fetch(1'b0, 64'h0, 0, 32'h0000_0033);
      check_eq("seq_pc", bus.pc, 64'h108);
      do_fetch(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'hABCD_0003);
      check_eq("wrap_pc", bus.pc, 64'h0);

      // Misaligned fetch goes to sticky ERR
      bus.pc_load   = 1'b1;
      bus.pc_target = 64'h102;
      tick();
      bus.pc_load     = 1'b0;
      bus.fetch_start = 1'b1;
      check_eq("mis_rd_idle", 64'(bus.mem_rd), 64'd0);
      tick();
      bus.fetch_start = 1'b0;
      check_eq("mis_err", 64'(bus.fetch_err), 64'd1);
      check_eq("mis_busy", 64'(bus.busy), 64'd1);
      for (int i = 0; i < 4; i++) begin
         check_eq("mis_rd_low", 64'(bus.mem_rd), 64'd0);
         bus.fetch_start = 1'b1;
         bus.pc_load     = 1'b1;
         bus.pc_target   = 64'h200;
         tick();
      end
      check_eq("mis_err_sticky", 64'(bus.fetch_err), 64'd1);
      check_eq("mis_pc_hold", bus.pc, 64'h102);
      do_reset();
      check_eq("mis_err_cleared", 64'(bus.fetch_err), 64'd0);
      check_eq("mis_pc_reset", bus.pc, 64'h0);

      // Timeout: no ready for 15 FETCH cycles
      do_fetch(1'b0, 64'h0, 0, 32'h0011_2233);
      bus.fetch_start = 1'b1;
      tick();
      bus.fetch_start = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         check_eq("to_rd_high", 64'(bus.mem_rd), 64'd1);
         tick();
      end
      check_eq("to_err", 64'(bus.fetch_err), 64'd1);
      check_eq("to_rd_low", 64'(bus.mem_rd), 64'd0);
      check_eq("to_pc_hold", bus.pc, 64'd4);
      check_eq("to_ir_hold", 64'(bus.Instr31_0), 64'h0011_2233);

      // Ready on the 15th FETCH cycle completes normally
      do_reset();
      do_fetch(1'b0, 64'h0, 14, 32'h7777_0013);
      check_eq("to_edge_err", 64'(bus.fetch_err), 64'd0);
      check_eq("to_edge_pc", bus.pc, 64'd4);

      // Reset on the second FETCH cycle aborts the read
      bus.fetch_start = 1'b1;
      tick();
      bus.fetch_start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset         = 1'b0;
      m_pc          = 64'h0;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h5555_5555;
      check_eq("abort_rd_low", 64'(bus.mem_rd), 64'd0);
      check_eq("abort_pc", bus.pc, 64'h0);
      check_eq("abort_ir", 64'(bus.Instr31_0), 64'd0);
      tick();
      bus.mem_ready = 1'b0;
      check_eq("abort_no_valid", 64'(bus.instr_valid), 64'd0);
      check_eq("abort_idle", 64'(bus.busy), 64'd0);
      tick();

      check_eq("sb_drained", 64'(sb.size()), 64'd0);
      check_eq("valid_count", 64'(n_valid), 64'(n_pushed));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the PC value after reset.
REQ-002 Parameter TIMEOUT, default 15, SHALL be the maximum number of FETCH cycles allowed without mem_ready (range 1..255).
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous and active-high.
REQ-005 fetch_start  input  1  SHALL be the control-unit request to fetch the instruction at pc.
REQ-006 pc_load  input  1  SHALL load pc_target into pc (branch/jump redirect).
REQ-007 pc_target  input  64  SHALL be the redirect address.
REQ-008 mem_rd  output  1  SHALL be the instruction memory read strobe.
REQ-009 mem_addr  output  64  SHALL be the byte address of the read.
REQ-010 mem_ready  input  1  SHALL mean mem_rdata is valid this cycle.
REQ-011 mem_rdata  input  32  SHALL be the instruction word from memory.
REQ-012 Instr31_0  output  32  SHALL be the instruction register contents.
REQ-013 opcode  output  7  SHALL equal Instr31_0[6:0].
REQ-014 pc  output  64  SHALL be the current PC.
REQ-015 instr_valid  output  1  SHALL pulse one cycle when a new instruction is latched.
REQ-016 busy  output  1  SHALL be high in every state except IDLE.
REQ-017 fetch_err  output  1  SHALL flag misaligned fetch or memory timeout.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, DONE, ERR.
REQ-019 IDLE: mem_rd=0; pc_load=1 SHALL set pc<=pc_target; fetch_start=1 SHALL go to FETCH.
REQ-020 Simultaneous pc_load and fetch_start in IDLE SHALL fetch from pc_target (pc updated first, FETCH uses new pc).
REQ-021 fetch_start with effective pc[1:0]!=2'b00 SHALL go to ERR instead of FETCH; mem_rd never asserts.
REQ-022 FETCH: mem_rd=1 and mem_addr=pc every cycle, mem_addr stable until mem_ready.
REQ-023 FETCH with mem_ready=1: Instr31_0<=mem_rdata, pc<=pc+4 (modulo 2^64), next state DONE.
REQ-024 FETCH: a cycle counter SHALL clear on FETCH entry and count FETCH cycles; if the TIMEOUT-th FETCH cycle ends with mem_ready=0, next state ERR, pc and Instr31_0 unchanged.
REQ-025 mem_ready=1 on the TIMEOUT-th FETCH cycle SHALL complete the fetch normally (ready wins over timeout).
REQ-026 DONE: instr_valid=1, mem_rd=0, next state IDLE unconditionally.
REQ-027 ERR: fetch_err=1, mem_rd=0; state SHALL remain ERR until reset; fetch_start and pc_load ignored.
REQ-028 pc_load and fetch_start SHALL be ignored in FETCH and DONE.
REQ-029 mem_ready and mem_rdata SHALL be ignored outside FETCH.
REQ-030 Minimum latency: fetch_start sampled in cycle 0, mem_rd in cycle 1, instr_valid in cycle 2 when mem_ready is high in cycle 1.
REQ-031 Instr31_0 SHALL hold its value until the next successful fetch.
REQ-032 mem_rd, mem_addr, busy, instr_valid, fetch_err SHALL be decoded from registered state and pc only (no input-to-output combinational path).

Reset
REQ-033 reset=1 at a rising edge SHALL set state=IDLE, pc=RESET_PC, Instr31_0=0, counter=0, overriding all other inputs.
REQ-034 After reset: mem_rd=0, instr_valid=0, busy=0, fetch_err=0, opcode=0, mem_addr=RESET_PC.
REQ-035 reset during FETCH SHALL abort the read: mem_rd=0 from the next cycle, no IR/pc update, late mem_ready ignored.

Verification
REQ-036 Reset, fetch_start, mem_ready in first FETCH cycle with rdata=0x00500093 -> instr_valid at cycle 2, opcode=0x13, Instr31_0=0x00500093, pc=4.
REQ-037 mem_ready withheld 3 cycles -> mem_rd high 4 cycles, mem_addr=0 constant, busy high, instr_valid once after ready, pc=4.
REQ-038 pc_load=1, pc_target=0x100, fetch_start=1 same cycle -> mem_addr=0x100, pc=0x104 after fetch; pc_target=0xFFFFFFFFFFFFFFFC -> pc wraps to 0.
REQ-039 pc_load 0x102 then fetch_start -> ERR next cycle, fetch_err=1 sticky, mem_rd never high; reset clears.
REQ-040 TIMEOUT=15, no mem_ready -> ERR after 15 FETCH cycles, pc and IR unchanged; separate run with ready on cycle 15 -> normal DONE.
REQ-041 reset asserted on second FETCH cycle, mem_ready one cycle later -> IDLE, pc=RESET_PC, Instr31_0=0, no instr_valid.
